switch_send_queue: RTL and testbench
====================================

Name: switch_send_queue

Overview:
Per-core outbound message queue sitting directly upstream of the Switch send port of one core. It accepts vector messages (destination core index plus WIDTH shortreal elements) from the core and buffers them in a DEPTH-entry FIFO. It presents the head entry to the Switch using the send_ready/send_ok handshake, so the core is never blocked while the Switch is busy unless the queue is full.

Parameters:
WIDTH, 2, shortreal elements per message (matches Switch WIDTH)
CORE_SIZE, 3, number of cores on the Switch
DEPTH, 4, FIFO entries; power of two, >= 2
CORE_ADDR_SIZE, $clog2(CORE_SIZE), destination index width (derived)
CNT_SIZE, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
enq_valid  input  1  core offers a message this cycle
enq_core_idx  input  CORE_ADDR_SIZE  destination core of offered message
enq_data  input  shortreal[WIDTH]  payload of offered message
enq_ready  output  1  queue can accept; high iff count < DEPTH
count  output  CNT_SIZE  current occupancy
send_ready  output  1  to Switch: head entry valid
send_core_idx  output  CORE_ADDR_SIZE  to Switch: head destination
send_data  output  shortreal[WIDTH]  to Switch: head payload
send_ok  input  1  from Switch: head accepted this cycle

Behaviour:
- Reset (posedge with reset=1): head=tail=0, count=0. Outputs: enq_ready=1, send_ready=0, send_core_idx=0, send_data=0.0. Any in-flight entries are discarded; send_ok is ignored during the reset cycle.
- Push: on posedge with enq_valid && enq_ready, write {enq_core_idx, enq_data} to mem[tail]; tail increments modulo DEPTH.
- Pop: on posedge with send_ready && send_ok, head increments modulo DEPTH. send_ok with send_ready=0 is ignored.
- count: next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Outputs are combinational from registered state: send_ready = (count != 0); send_core_idx/send_data = mem[head]. When empty, these outputs are forced to 0 / 0.0.
- Latency: a message pushed at edge N is visible on send_* after edge N; the earliest acceptance is at edge N+1.
- Handshake: while send_ready=1 and no pop occurs, send_core_idx/send_data hold stable across cycles (Switch sender-blocked case).
- Full: enq_ready=0 when count==DEPTH. A push offered when full is dropped and has no effect, even if a pop occurs in the same cycle (no full-bypass).
- Empty: no bypass. A push to an empty queue does not appear on send_* in the same cycle.
- Wrap-around: pointers are CORE_ADDR-independent $clog2(DEPTH)-bit counters. FIFO order is preserved across wrap.
- An enq_core_idx >= CORE_SIZE is stored unchanged; range checking is the Switch's responsibility.
- No FSM beyond the FIFO state {EMPTY, PARTIAL, FULL}, which is implied by count.

Optional Feature:
SWITCH_SEND_QUEUE_STATS_EN
- Defined: adds outputs sent_total[31:0] and stall_cycles[31:0], both reset to 0.
  - sent_total increments on each pop.
  - stall_cycles increments each cycle with send_ready=1 && send_ok=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package switch_pkg holds:
  - typedef shortreal vec_t[WIDTH]
  - typedef struct msg_t {core_idx, data}
  - helper localparam for CORE_ADDR_SIZE
- The package is shared with the Switch and receive-side blocks.
- One natural sub-module: switch_fifo_mem (DEPTH x msg_t storage with a write port and an async read port). Pointer and count logic stay in the top module.

Test Plan:
1. Reset with stale inputs, then idle → enq_ready=1, send_ready=0, count=0. Assert reset mid-queue with count=3 → next cycle count=0, send_ready=0.
2. Push {idx=1, data=11,13} with send_ok=0 for 4 cycles → send_ready=1, send_core_idx=1, data 11/13 stable. Then send_ok=1 for one cycle → pop; count=0, send_ready=0.
3. Push 4 messages (data 1..4) with send_ok=0 → count=4, enq_ready=0. A 5th push (data 5) is dropped. Then hold send_ok=1 → order 1,2,3,4; data 5 never appears.
4. Full queue with a simultaneous push (data 9) and send_ok=1 → pop occurs, push dropped, count=3.
5. Partial queue (count=2) with a simultaneous push and pop → count stays 2. Drive 10 pushes/pops to force wrap-around → FIFO order preserved.
6. With SWITCH_SEND_QUEUE_STATS_EN: 3 stall cycles then 2 pops → stall_cycles=3, sent_total=2. Without the macro the bench compiles without the stats ports.

Source files
------------

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
// Types and constants shared by the Switch, the per-core send queue and the
// receive-side blocks.
//   WIDTH          : elements per vector message
//   CORE_SIZE      : number of cores attached to the Switch
//   CORE_ADDR_SIZE : width of a destination core index
//   vec_t          : WIDTH single-precision elements, each held as its
//                    IEEE-754 bit pattern (element 0 in the low 32 bits)
//   msg_t          : {destination core index, payload}
// ---------------------------------------------------------------------------
package switch_pkg;

    localparam int WIDTH          = 2;
    localparam int CORE_SIZE      = 3;
    localparam int CORE_ADDR_SIZE = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1;

    // One shortreal element is carried as its raw 32-bit encoding so that the
    // payload can live in plain flops / RAM and cross module ports unchanged.
    typedef logic [31:0] f32_bits_t;
    typedef logic [WIDTH-1:0][31:0] vec_t;
    typedef logic [CORE_ADDR_SIZE-1:0] core_idx_t;

    typedef struct packed {
        core_idx_t core_idx;
        vec_t      data;
    } msg_t;

    // Occupancy counter width for a FIFO of the given depth (0..depth).
    function automatic int cnt_size(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/switch_send_queue_if.sv
// ---------------------------------------------------------------------------
// switch_send_queue_if
// Bundles the core-side enqueue port and the Switch-side send port of one
// per-core send queue.
//   enq_valid/enq_core_idx/enq_data : core offers a message
//   enq_ready                       : queue has room (count < DEPTH)
//   count                           : current occupancy
//   send_ready/send_core_idx/send_data : head entry presented to the Switch
//   send_ok                         : Switch accepted the head this cycle
// Modports:
//   slave  : the queue itself
//   master : the core + Switch side that drives enq_* and send_ok
// ---------------------------------------------------------------------------
interface switch_send_queue_if
    import switch_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    localparam int CNT_SIZE = cnt_size(DEPTH);

    logic                enq_valid;
    core_idx_t           enq_core_idx;
    vec_t                enq_data;
    logic                enq_ready;
    logic [CNT_SIZE-1:0] count;

    logic                send_ready;
    core_idx_t           send_core_idx;
    vec_t                send_data;
    logic                send_ok;

    modport slave (
        input  enq_valid, enq_core_idx, enq_data, send_ok,
        output enq_ready, count, send_ready, send_core_idx, send_data
    );

    modport master (
        output enq_valid, enq_core_idx, enq_data, send_ok,
        input  enq_ready, count, send_ready, send_core_idx, send_data
    );

endinterface

// File: rtl/switch_fifo_mem.sv
// ---------------------------------------------------------------------------
// switch_fifo_mem
// DEPTH x msg_t storage for the send queue: one synchronous write port and
// one asynchronous read port (the head entry must be visible in the same
// cycle the pointer moves onto it).
//   clock   : write clock
//   wr_en   : write wr_data into mem[wr_addr] on posedge
//   wr_addr : write index
//   wr_data : message to store
//   rd_addr : read index
//   rd_data : mem[rd_addr], combinational
// ---------------------------------------------------------------------------
module switch_fifo_mem
    import switch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  msg_t             wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output msg_t             rd_data
);

    msg_t mem [DEPTH];

    // Storage carries no reset; validity is tracked by the owner's count.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/switch_send_queue.sv
// ---------------------------------------------------------------------------
// switch_send_queue
// Per-core outbound message queue in front of the Switch send port. Messages
// from the core are buffered in a DEPTH-entry FIFO and the head entry is
// offered to the Switch with the send_ready/send_ok handshake, so the core
// only stalls when the queue is full.
//   clock : single clock, all state updates on posedge
//   reset : synchronous, active-high
//   q     : switch_send_queue_if.slave (enqueue + send ports, count)
//   sent_total, stall_cycles : saturating statistics counters, present only
//                              when SWITCH_SEND_QUEUE_STATS_EN is defined
// Notes:
//   - No full-bypass: a push offered while full is dropped even if the head
//     pops in the same cycle.
//   - No empty-bypass: a push is visible on send_* only after its edge.
//   - send_core_idx/send_data read as zero while the queue is empty.
// ---------------------------------------------------------------------------
module switch_send_queue
    import switch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    switch_send_queue_if.slave  q
`ifdef SWITCH_SEND_QUEUE_STATS_EN
    ,
    output logic [31:0]         sent_total,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_SIZE = cnt_size(DEPTH);

    logic [PTR_W-1:0]    head_reg, head_next;
    logic [PTR_W-1:0]    tail_reg, tail_next;
    logic [CNT_SIZE-1:0] count_reg, count_next;

    logic push;
    logic pop;
    logic not_empty;
    logic not_full;
    msg_t wr_msg;
    msg_t head_msg;

    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg != CNT_SIZE'(DEPTH));

    // The full check uses the registered count only, which is what keeps a
    // same-cycle pop from letting a push in when full.
    assign push = q.enq_valid && not_full;
    assign pop  = not_empty && q.send_ok;

    assign wr_msg.core_idx = q.enq_core_idx;
    assign wr_msg.data     = q.enq_data;

    switch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push && !reset),
        .wr_addr (tail_reg),
        .wr_data (wr_msg),
        .rd_addr (head_reg),
        .rd_data (head_msg)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = tail_reg + PTR_W'(1);
        end
        if (pop) begin
            head_next = head_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_SIZE'(1);
            2'b01:   count_next = count_reg - CNT_SIZE'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign q.enq_ready     = not_full;
    assign q.count         = count_reg;
    assign q.send_ready    = not_empty;
    // Mask stale RAM contents so an empty queue presents all-zero outputs.
    assign q.send_core_idx = not_empty ? head_msg.core_idx : '0;
    assign q.send_data     = not_empty ? head_msg.data     : '0;

`ifdef SWITCH_SEND_QUEUE_STATS_EN
    logic [31:0] sent_total_reg,   sent_total_next;
    logic [31:0] stall_cycles_reg, stall_cycles_next;

    always_comb begin
        sent_total_next   = sent_total_reg;
        stall_cycles_next = stall_cycles_reg;
        if (pop && (sent_total_reg != 32'hFFFF_FFFF)) begin
            sent_total_next = sent_total_reg + 32'd1;
        end
        // Head is waiting on the Switch this cycle.
        if (not_empty && !q.send_ok && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_next = stall_cycles_reg + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sent_total_reg   <= '0;
            stall_cycles_reg <= '0;
        end else begin
            sent_total_reg   <= sent_total_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign sent_total   = sent_total_reg;
    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_switch_send_queue.sv
// ---------------------------------------------------------------------------
// tb_switch_send_queue
// Directed self-checking bench for switch_send_queue (DEPTH=4). Payload
// elements are integers encoded as IEEE-754 single-precision bit patterns.
// Define SWITCH_SEND_QUEUE_STATS_EN to also exercise the statistics ports.
// ---------------------------------------------------------------------------
module tb_switch_send_queue;
    import switch_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    switch_send_queue_if #(.DEPTH(DEPTH)) q_if ();

`ifdef SWITCH_SEND_QUEUE_STATS_EN
    logic [31:0] sent_total;
    logic [31:0] stall_cycles;
`endif

    switch_send_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .q            (q_if)
`ifdef SWITCH_SEND_QUEUE_STATS_EN
        ,
        .sent_total   (sent_total),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small positive integer -> single-precision bit pattern.
    function automatic logic [31:0] f32(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) begin
            if (((n >> i) & 1) != 0) e = i;
        end
        m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic vec_t mk(input int a, input int b);
        vec_t v;
        v[0] = f32(a);
        v[1] = f32(b);
        return v;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input int idx, input int a, input int b);
        q_if.enq_valid    = 1'b1;
        q_if.enq_core_idx = core_idx_t'(idx);
        q_if.enq_data     = mk(a, b);
        step();
        q_if.enq_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        q_if.enq_valid    = 1'b1;
        q_if.enq_core_idx = core_idx_t'(2);
        q_if.enq_data     = mk(7, 8);
        q_if.send_ok      = 1'b1;
        step();
        step();
        reset          = 1'b0;
        q_if.enq_valid = 1'b0;
        q_if.send_ok   = 1'b0;
        step();
        total++;
        if (q_if.enq_ready !== 1'b1) begin
            bad++; $display("FAIL reset_enq_ready: got %b want 1", q_if.enq_ready);
        end
        total++;
        if (q_if.send_ready !== 1'b0) begin
            bad++; $display("FAIL reset_send_ready: got %b want 0", q_if.send_ready);
        end
        total++;
        if (q_if.count !== 3'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", q_if.count);
        end
        total++;
        if (q_if.send_core_idx !== '0 || q_if.send_data !== '0) begin
            bad++; $display("FAIL reset_outputs: got idx=%0d data=%h want 0/0",
                            q_if.send_core_idx, q_if.send_data);
        end
        $display("reset: idle state checked");

        push_one(0, 1, 1);
        push_one(1, 2, 2);
        push_one(2, 3, 3);
        total++;
        if (q_if.count !== 3'd3) begin
            bad++; $display("FAIL midreset_precount: got %0d want 3", q_if.count);
        end
        reset        = 1'b1;
        q_if.send_ok = 1'b1;
        step();
        reset        = 1'b0;
        q_if.send_ok = 1'b0;
        total++;
        if (q_if.count !== 3'd0 || q_if.send_ready !== 1'b0 || q_if.enq_ready !== 1'b1) begin
            bad++; $display("FAIL midreset: got count=%0d send_ready=%b enq_ready=%b want 0/0/1",
                            q_if.count, q_if.send_ready, q_if.enq_ready);
        end
        $display("reset: mid-queue reset checked");
    endtask

    task automatic test_hold();
        q_if.send_ok = 1'b0;
        push_one(1, 11, 13);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (q_if.send_ready !== 1'b1 || q_if.send_core_idx !== core_idx_t'(1) ||
                q_if.send_data !== mk(11, 13)) begin
                bad++; $display("FAIL hold_cycle%0d: got rdy=%b idx=%0d data=%h want 1/1/%h",
                                c, q_if.send_ready, q_if.send_core_idx, q_if.send_data, mk(11, 13));
            end
            step();
        end
        q_if.send_ok = 1'b1;
        step();
        q_if.send_ok = 1'b0;
        total++;
        if (q_if.count !== 3'd0 || q_if.send_ready !== 1'b0 || q_if.send_data !== '0) begin
            bad++; $display("FAIL hold_pop: got count=%0d rdy=%b data=%h want 0/0/0",
                            q_if.count, q_if.send_ready, q_if.send_data);
        end
        $display("hold: stable head over 4 blocked cycles then pop");
    endtask

    task automatic test_full();
        q_if.send_ok = 1'b0;
        for (int k = 1; k <= 4; k++) push_one(k % 3, k, k + 10);
        total++;
        if (q_if.count !== 3'd4 || q_if.enq_ready !== 1'b0) begin
            bad++; $display("FAIL full_state: got count=%0d enq_ready=%b want 4/0",
                            q_if.count, q_if.enq_ready);
        end
        push_one(2, 5, 15);
        total++;
        if (q_if.count !== 3'd4) begin
            bad++; $display("FAIL full_drop: got count=%0d want 4", q_if.count);
        end
        q_if.send_ok = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (q_if.send_ready !== 1'b1 || q_if.send_core_idx !== core_idx_t'(k % 3) ||
                q_if.send_data !== mk(k, k + 10)) begin
                bad++; $display("FAIL full_order%0d: got rdy=%b idx=%0d data=%h want 1/%0d/%h",
                                k, q_if.send_ready, q_if.send_core_idx, q_if.send_data,
                                k % 3, mk(k, k + 10));
            end
            step();
        end
        q_if.send_ok = 1'b0;
        total++;
        if (q_if.send_ready !== 1'b0 || q_if.count !== 3'd0) begin
            bad++; $display("FAIL full_drained: got rdy=%b count=%0d want 0/0",
                            q_if.send_ready, q_if.count);
        end
        $display("full: order 1..4 drained, dropped push absent");
    endtask

    task automatic test_full_simul();
        q_if.send_ok = 1'b0;
        for (int k = 21; k <= 24; k++) push_one(1, k, k);
        q_if.enq_valid    = 1'b1;
        q_if.enq_core_idx = core_idx_t'(0);
        q_if.enq_data     = mk(9, 9);
        q_if.send_ok      = 1'b1;
        step();
        q_if.enq_valid = 1'b0;
        q_if.send_ok   = 1'b0;
        total++;
        if (q_if.count !== 3'd3 || q_if.send_data !== mk(22, 22)) begin
            bad++; $display("FAIL full_simul: got count=%0d head=%h want 3/%h",
                            q_if.count, q_if.send_data, mk(22, 22));
        end
        q_if.send_ok = 1'b1;
        for (int k = 22; k <= 24; k++) begin
            total++;
            if (q_if.send_data !== mk(k, k)) begin
                bad++; $display("FAIL full_simul_drain%0d: got %h want %h",
                                k, q_if.send_data, mk(k, k));
            end
            step();
        end
        q_if.send_ok = 1'b0;
        total++;
        if (q_if.send_ready !== 1'b0) begin
            bad++; $display("FAIL full_simul_empty: got rdy=%b want 0", q_if.send_ready);
        end
        $display("full_simul: pop taken, push while full dropped");
    endtask

    task automatic test_wrap();
        int exp_q[$];
        int e;
        q_if.send_ok = 1'b0;
        push_one(0, 30, 30); exp_q.push_back(30);
        push_one(0, 31, 31); exp_q.push_back(31);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            total++;
            if (q_if.send_data !== mk(e, e)) begin
                bad++; $display("FAIL wrap_head%0d: got %h want %h", i, q_if.send_data, mk(e, e));
            end
            q_if.enq_valid    = 1'b1;
            q_if.enq_core_idx = core_idx_t'(i % 3);
            q_if.enq_data     = mk(32 + i, 32 + i);
            q_if.send_ok      = 1'b1;
            exp_q.push_back(32 + i);
            step();
            total++;
            if (q_if.count !== 3'd2) begin
                bad++; $display("FAIL wrap_count%0d: got %0d want 2", i, q_if.count);
            end
        end
        q_if.enq_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (q_if.send_data !== mk(e, e)) begin
                bad++; $display("FAIL wrap_drain: got %h want %h", q_if.send_data, mk(e, e));
            end
            step();
        end
        q_if.send_ok = 1'b0;
        $display("wrap: 10 simultaneous push/pop cycles, order preserved");
    endtask

`ifdef SWITCH_SEND_QUEUE_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (sent_total !== 32'd0 || stall_cycles !== 32'd0) begin
            bad++; $display("FAIL stats_reset: got sent=%0d stall=%0d want 0/0",
                            sent_total, stall_cycles);
        end
        // Second push cycle already has a waiting head: 1 stall, then 2 more.
        push_one(1, 40, 40);
        push_one(2, 41, 41);
        step();
        step();
        q_if.send_ok = 1'b1;
        step();
        step();
        q_if.send_ok = 1'b0;
        step();
        total++;
        if (stall_cycles !== 32'd3 || sent_total !== 32'd2) begin
            bad++; $display("FAIL stats_counts: got stall=%0d sent=%0d want 3/2",
                            stall_cycles, sent_total);
        end
        $display("stats: stall and sent counters checked");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total             = 0;
        bad               = 0;
        reset             = 1'b1;
        q_if.enq_valid    = 1'b0;
        q_if.enq_core_idx = '0;
        q_if.enq_data     = '0;
        q_if.send_ok      = 1'b0;
        test_reset();
        test_hold();
        test_full();
        test_full_simul();
        test_wrap();
`ifdef SWITCH_SEND_QUEUE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
